// File: rtl/aes_key_expansion.sv
// AES-128 iterative key schedule with an 11-entry round-key table.
// It takes one cipher key through a valid/ready handshake and expands one
// round key per cycle. Any round key can then be read by index with a
// one-cycle registered latency.
// Ports:
//   Clk, Rst_n : clock and synchronous active-low reset.
//   Key_valid  : Key carries a new cipher key.
//   Key_ready  : block can accept a key.
//   Key        : cipher key, byte 0 is [127:120].
//   Keys_ready : all round keys in the table are valid.
//   Round_idx  : round key index to read (0..10; 11..15 read as zero).
//   Round_key  : registered round key selected by Round_idx.
module aes_key_expansion #(
  parameter int unsigned KEY_WIDTH  = 128,
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Key_valid,
  output logic                 Key_ready,
  input  logic [KEY_WIDTH-1:0] Key,
  output logic                 Keys_ready,
  input  logic [3:0]           Round_idx,
  output logic [KEY_WIDTH-1:0] Round_key
);

  localparam int unsigned NUM_KEYS = NUM_ROUNDS + 1;
  localparam int unsigned CNT_W    = 4;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 key_ready_q, key_ready_d;
  logic                 keys_ready_q, keys_ready_d;
  logic [KEY_WIDTH-1:0] round_key_q, round_key_d;
  logic [KEY_WIDTH-1:0] rk_q [NUM_KEYS];

  logic                 xfer_c;
  logic                 wr_en_c;
  logic [KEY_WIDTH-1:0] prev_rk_c;
  logic [KEY_WIDTH-1:0] next_rk_c;

  // Entry b sits at bit offset (255-b)*8, and 255-b is ~b.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [10:0] base;
    base = {~b, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // One key-schedule step: rk[cnt] from rk[cnt-1].
  always_comb begin
    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    prev_rk_c = '0;
    if (cnt_q != '0 && cnt_q <= CNT_W'(NUM_ROUNDS)) begin
      prev_rk_c = rk_q[cnt_q - CNT_W'(1)];
    end
    w0  = prev_rk_c[127:96];
    w1  = prev_rk_c[95:64];
    w2  = prev_rk_c[63:32];
    w3  = prev_rk_c[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
           sub_byte(rot[15:8]),  sub_byte(rot[7:0])} ^ {rcon(cnt_q), 24'h0};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    next_rk_c = {n0, n1, n2, n3};
  end

  // Next-state, handshake and read-port logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    keys_ready_d = keys_ready_q;
    wr_en_c      = 1'b0;
    xfer_c       = Key_valid && key_ready_q;
    round_key_d  = '0;

    case (state_q)
      IDLE, READY: begin
        if (xfer_c) begin
          state_d      = EXPAND;
          cnt_d        = CNT_W'(1);
          keys_ready_d = 1'b0;
        end
      end
      EXPAND: begin
        wr_en_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_ROUNDS)) begin
          state_d      = READY;
          keys_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered copy of the state decode so Key_ready is low throughout reset.
    key_ready_d = (state_d != EXPAND);

    if (Round_idx <= 4'(NUM_ROUNDS)) begin
      round_key_d = rk_q[Round_idx];
    end
  end

  // Control and output registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      key_ready_q  <= 1'b0;
      keys_ready_q <= 1'b0;
      round_key_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_ready_q  <= key_ready_d;
      keys_ready_q <= keys_ready_d;
      round_key_q  <= round_key_d;
    end
  end

  // Round-key table; a read on a write edge sees the old entry.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      if (xfer_c) begin
        rk_q[0] <= Key;
      end
      if (wr_en_c) begin
        rk_q[cnt_q] <= next_rk_c;
      end
    end
  end

  assign Key_ready  = key_ready_q;
  assign Keys_ready = keys_ready_q;
  assign Round_key  = round_key_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion. The reference builds the S-box
// from GF(2^8) inversion plus the affine map, and expands keys with the
// 44-word FIPS-197 recurrence.
module tb_aes_key_expansion;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         Key_valid;
  logic         Key_ready;
  logic [127:0] Key;
  logic         Keys_ready;
  logic [3:0]   Round_idx;
  logic [127:0] Round_key;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] m_rk [11];

  aes_key_expansion dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Key_valid  (Key_valid),
    .Key_ready  (Key_ready),
    .Key        (Key),
    .Keys_ready (Keys_ready),
    .Round_idx  (Round_idx),
    .Round_key  (Round_key)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = '0;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p ^= aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = '0;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_m[temp[31:24]], sbox_m[temp[23:16]], sbox_m[temp[15:8]], sbox_m[temp[7:0]]};
        temp ^= {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic send_key(input logic [127:0] k);
    check_eq("key_ready_before_xfer", 128'(Key_ready), 128'd1);
    Key       = k;
    Key_valid = 1'b1;
    tick();
    Key_valid = 1'b0;
  endtask

  // Cycles from the transfer edge until Keys_ready rises; 0 means timeout.
  task automatic wait_ready(output int lat, output int kr_low);
    lat    = 0;
    kr_low = 0;
    for (int n = 1; n <= 20; n++) begin
      if (!Key_ready) kr_low++;
      tick();
      if (Keys_ready) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic read_key(input logic [3:0] idx, output logic [127:0] val);
    Round_idx = idx;
    tick();
    val = Round_key;
  endtask

  initial begin
    int           lat, kr_low;
    logic [127:0] v;
    logic [127:0] k;
    int           order [11];

    build_sbox();
    Rst_n     = 1'b0;
    Key_valid = 1'b1;
    Key       = FIPS_KEY;
    Round_idx = 4'd0;

    // Reset held with Key_valid asserted.
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("rst_key_ready", 128'(Key_ready), 128'd0);
      check_eq("rst_keys_ready", 128'(Keys_ready), 128'd0);
      check_eq("rst_round_key", Round_key, 128'd0);
    end
    Rst_n     = 1'b1;
    Key_valid = 1'b0;
    tick();
    check_eq("post_rst_key_ready", 128'(Key_ready), 128'd1);
    for (int c = 0; c < 3; c++) tick();
    check_eq("idle_key_ready", 128'(Key_ready), 128'd1);
    check_eq("idle_keys_ready", 128'(Keys_ready), 128'd0);

    // FIPS-197 key.
    model_expand(FIPS_KEY);
    send_key(FIPS_KEY);
    check_eq("fips_key_ready_low", 128'(Key_ready), 128'd0);
    wait_ready(lat, kr_low);
    check_eq("fips_latency", 128'(lat), 128'd10);
    check_eq("fips_key_ready_low_cycles", 128'(kr_low), 128'd10);
    check_eq("fips_key_ready_back", 128'(Key_ready), 128'd1);
    read_key(4'd0, v);  check_eq("fips_rk0", v, FIPS_KEY);
    read_key(4'd1, v);  check_eq("fips_rk1", v, FIPS_RK1);
    read_key(4'd10, v); check_eq("fips_rk10", v, FIPS_RK10);

    // Descending sweep, pipelined one index per cycle.
    Round_idx = 4'd10;
    tick();
    for (int i = 9; i >= 0; i--) begin
      check_eq($sformatf("sweep_rk%0d", i + 1), Round_key, m_rk[i+1]);
      Round_idx = 4'(i);
      tick();
    end
    check_eq("sweep_rk0", Round_key, m_rk[0]);
    read_key(4'd12, v); check_eq("idx12_zero", v, 128'd0);
    for (int c = 0; c < 5; c++) tick();
    check_eq("ready_hold", 128'(Keys_ready), 128'd1);

    // Re-key from READY with the zero key; read rk0 on the transfer edge.
    Round_idx = 4'd0;
    send_key(128'd0);
    check_eq("rekey_read_pre_xfer", Round_key, FIPS_KEY);
    check_eq("rekey_keys_ready_low", 128'(Keys_ready), 128'd0);
    // Offer the FIPS key while expanding; it must be ignored.
    kr_low    = 1;
    Key       = FIPS_KEY;
    Key_valid = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (!Key_ready) kr_low++;
      check_eq("rekey_keys_ready_expand", 128'(Keys_ready), 128'd0);
    end
    Key_valid = 1'b0;
    tick();
    check_eq("rekey_key_ready_low_cycles", 128'(kr_low), 128'd10);
    check_eq("rekey_keys_ready_at_10", 128'(Keys_ready), 128'd1);
    model_expand(128'd0);
    for (int i = 0; i < 11; i++) begin
      read_key(4'(i), v);
      check_eq($sformatf("zero_rk%0d", i), v, m_rk[i]);
    end
    read_key(4'd1, v);  check_eq("zero_rk1_const", v, ZERO_RK1);
    read_key(4'd10, v); check_eq("zero_rk10_const", v, ZERO_RK10);

    // Randomized keys, table read in shuffled order plus an out-of-range index.
    for (int t = 0; t < 6; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k);
      send_key(k);
      wait_ready(lat, kr_low);
      check_eq($sformatf("rand%0d_latency", t), 128'(lat), 128'd10);
      for (int i = 0; i < 11; i++) order[i] = i;
      for (int i = 10; i > 0; i--) begin
        int j, tmp;
        j = int'($urandom_range(i, 0));
        tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int i = 0; i < 11; i++) begin
        read_key(4'(order[i]), v);
        check_eq($sformatf("rand%0d_rk%0d", t, order[i]), v, m_rk[order[i]]);
      end
      read_key(4'($urandom_range(15, 11)), v);
      check_eq($sformatf("rand%0d_oor", t), v, 128'd0);
    end

    // Reset pulse in the middle of an expansion.
    send_key({$urandom, $urandom, $urandom, $urandom});
    for (int c = 0; c < 5; c++) tick();
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    check_eq("midrst_keys_ready", 128'(Keys_ready), 128'd0);
    check_eq("midrst_key_ready", 128'(Key_ready), 128'd0);
    check_eq("midrst_round_key", Round_key, 128'd0);
    for (int i = 0; i < 11; i++) begin
      read_key(4'(i), v);
      check_eq($sformatf("midrst_rk%0d", i), v, 128'd0);
    end
    check_eq("midrst_keys_ready_stays", 128'(Keys_ready), 128'd0);
    model_expand(FIPS_KEY);
    send_key(FIPS_KEY);
    wait_ready(lat, kr_low);
    check_eq("midrst_fips_latency", 128'(lat), 128'd10);
    read_key(4'd10, v); check_eq("midrst_fips_rk10", v, FIPS_RK10);
    read_key(4'd5, v);  check_eq("midrst_fips_rk5", v, m_rk[5]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Iterative AES-128 key schedule that generates the round keys consumed by the round datapath's Key input.
- It accepts one cipher key, expands one round key per cycle into an internal 11-entry table, and then serves keys by round index.
- The round controller reads keys in ascending order for encryption and descending order for decryption, so a single table serves both directions.

Parameters:
- KEY_WIDTH, `AES_BLOCK_SIZE (128), cipher key and round key width; only 128 is supported.
- NUM_ROUNDS, 10, number of rounds; the table holds NUM_ROUNDS+1 entries.

Ports:
- Clk  input  1  clock; all logic is on the rising edge.
- Rst_n  input  1  synchronous, active-low reset.
- Key_valid  input  1  Key carries a new cipher key.
- Key_ready  output  1  block can accept a key.
- Key  input  KEY_WIDTH  cipher key; bits [127:120] are byte 0.
- Keys_ready  output  1  all 11 round keys are valid.
- Round_idx  input  4  round key index to read, 0..10.
- Round_key  output  KEY_WIDTH  registered round key for Round_idx.

Behaviour:
- Reset (Rst_n=0 at a clock edge):
  - state goes to IDLE; round counter goes to 0.
  - Key_ready=0 during reset, 1 on the first cycle after reset is released.
  - Keys_ready=0, Round_key=0, all table entries cleared to 0.
- Reset during EXPAND aborts the expansion; the table is cleared.
- Handshake:
  - A key transfer occurs on an edge with Key_valid && Key_ready.
  - Key_ready=1 in IDLE and READY, 0 in EXPAND.
- FSM transitions:
  - IDLE -> EXPAND on transfer.
  - EXPAND -> READY after rk[10] is written.
  - READY -> EXPAND on a new transfer.
  - There is no path back to IDLE except reset.
- Transfer edge:
  - rk[0] = Key; counter = 1.
  - Keys_ready drops to 0 at this same edge, including a re-key from READY.
- Each EXPAND edge computes rk[i] from rk[i-1], with i = counter, then increments the counter:
  - w0..w3 are the 32-bit words of rk[i-1], w0 = [127:96].
  - t = SubWord(RotWord(w3)) ^ {Rcon[i], 24'h0}.
  - RotWord rotates bytes left by one.
  - Rcon = 01,02,04,08,10,20,40,80,1b,36 for i = 1..10.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2; rk[i] = {n0,n1,n2,n3}.
  - SubWord uses 4 forward S-box lookups, implemented in the block as a function or case table.
- Latency:
  - rk[1] is written 1 edge after the transfer edge; rk[10] is written 10 edges after it.
  - Keys_ready=1 from the edge that writes rk[10], i.e. visible 10 cycles after the transfer cycle.
  - In READY, Keys_ready stays high until the next transfer.
- Read port:
  - Round_key <= rk[Round_idx] every edge, giving 1-cycle latency.
  - Round_idx 11..15 returns all zeros.
  - Reads are permitted in any state, but their content is only guaranteed when Keys_ready was 1 on the cycle Round_idx was sampled.
  - During EXPAND a read returns the current entry, which may be stale or partially updated.
- Simultaneous events:
  - Key_valid while in EXPAND is ignored; it is not queued, and the key must be held until Key_ready.
  - A transfer and a read on the same edge return the pre-transfer entry.
- Key_valid=0 in READY holds the table indefinitely.

Test Plan:
- Reset check: hold Rst_n=0 for 3 cycles with Key_valid=1.
  - Required: Key_ready=0, Keys_ready=0, Round_key=0 during reset.
  - After release, Key_ready=1 and the FSM stays in IDLE until a transfer.
- FIPS-197 key: transfer Key=2b7e151628aed2a6abf7158809cf4f3c.
  - Keys_ready rises exactly 10 cycles after the transfer.
  - Round_idx=0 reads the input key.
  - Round_idx=1 reads a0fafe1788542cb123a339392a6c7605.
  - Round_idx=10 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
- Zero key: transfer Key=0.
  - rk[1] = 62636363626363636263636362636363.
  - rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
- Descending read sweep: step Round_idx 10 down to 0, one per cycle.
  - Each key appears one cycle after its index; Round_idx=12 returns 0.
- Re-key and ignored key:
  - In READY, transfer the zero key: Keys_ready=0 on the next cycle and Key_ready=0 for 10 cycles.
  - Assert Key_valid with the FIPS key during EXPAND: it is ignored and the final table equals the zero-key schedule.
- Mid-expansion reset: pulse Rst_n=0 for 1 cycle 5 cycles after a transfer.
  - The table is cleared and Keys_ready stays 0.
  - A subsequent FIPS-key transfer yields a correct rk[10].
